// File: rtl/mm_accel_pkg.sv
// Shared constants, state encoding and index helper for the matrix multiplication accelerator.
package mm_accel_pkg;

    localparam int unsigned ACC_W  = 10;
    localparam int unsigned OPND_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    function automatic int unsigned row_major_idx(input int unsigned r, input int unsigned c,
                                                  input int unsigned n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/acc_word_select.sv
// Combinational N*N:1 mux picking one ACC_W-bit word out of a flattened snapshot.
module acc_word_select
    import mm_accel_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned ACC_W = mm_accel_pkg::ACC_W,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N*N*ACC_W-1:0] words,
    input  logic [IDX_W-1:0]     sel,
    output logic [ACC_W-1:0]     word
);

    always_comb begin
        word = '0;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                if (sel == IDX_W'(row_major_idx(r, c, N))) begin
                    word = words[row_major_idx(r, c, N)*ACC_W +: ACC_W];
                end
            end
        end
    end

endmodule

// File: rtl/mac_result_unloader.sv
// Snapshots the MAC accumulators on start, clears them, then streams words row-major.
// Optional macro RESULT_PARITY_EN adds an even-parity bit alongside each streamed word.
module mac_result_unloader
    import mm_accel_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned ACC_W = mm_accel_pkg::ACC_W,
    parameter int unsigned IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N*N*ACC_W-1:0] acc_flat,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [ACC_W-1:0]     out_data,
    output logic [IDX_W-1:0]     out_index,
    output logic                 out_last,
    output logic                 acc_clear,
    output logic                 busy,
`ifdef RESULT_PARITY_EN
    output logic                 out_parity,
`endif
    output logic                 done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [N*N*ACC_W-1:0] snap_q;
    logic [ACC_W-1:0]     sel_word;

    acc_word_select #(
        .N     (N),
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_sel (
        .words (snap_q),
        .sel   (idx_q),
        .word  (sel_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            acc_clear <= 1'b0;
            done      <= 1'b0;
        end else begin
            acc_clear <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        snap_q    <= acc_flat;
                        idx_q     <= '0;
                        state_q   <= ST_STREAM;
                        acc_clear <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    // out_valid is implied in this state, so ready alone completes a handshake
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= ST_IDLE;
                            done    <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid = (state_q == ST_STREAM);
    assign busy      = out_valid;
    assign out_data  = out_valid ? sel_word : '0;
    assign out_index = idx_q;
    assign out_last  = out_valid && (idx_q == LAST_IDX);

`ifdef RESULT_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_mac_result_unloader.sv
// Directed self-checking bench for mac_result_unloader (N=2, ACC_W=10, IDX_W=2).
module tb_mac_result_unloader;

    localparam int unsigned N     = 2;
    localparam int unsigned ACC_W = 10;
    localparam int unsigned IDX_W = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [N*N*ACC_W-1:0] acc_flat;
    logic                 out_ready;
    logic                 out_valid;
    logic [ACC_W-1:0]     out_data;
    logic [IDX_W-1:0]     out_index;
    logic                 out_last;
    logic                 acc_clear;
    logic                 busy;
    logic                 done;
`ifdef RESULT_PARITY_EN
    logic                 out_parity;
`endif

    int passed;
    int total;
    int hs_cnt;
    int clr_cnt;

    mac_result_unloader #(
        .N     (N),
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .acc_flat  (acc_flat),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .acc_clear (acc_clear),
        .busy      (busy),
`ifdef RESULT_PARITY_EN
        .out_parity(out_parity),
`endif
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Counts handshakes/clears seen at the coming edge, then samples 1 time unit after it.
    task automatic tick();
        if (out_valid && out_ready) hs_cnt++;
        if (acc_clear) clr_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input int data, input int idx, input int last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(data));
        chk({tag, "_index"}, 32'(out_index), 32'(idx));
        chk({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_index"}, 32'(out_index), 32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_clear"}, 32'(acc_clear), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        hs_cnt    = 0;
        clr_cnt   = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        acc_flat  = '0;

        // Reset then idle
        repeat (3) tick();
        chk_quiet("rst");
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk_quiet("idle");
        chk("idle_done", 32'(done), 32'd0);

        // Full stream with ready held high
        acc_flat  = {10'd1023, 10'd0, 10'd300, 10'd5};
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk_word("full0", 5, 0, 0);
        chk("full0_clear", 32'(acc_clear), 32'd1);
        chk("full0_busy", 32'(busy), 32'd1);
`ifdef RESULT_PARITY_EN
        chk("par5", 32'(out_parity), 32'd0);
`endif
        tick();
        chk_word("full1", 300, 1, 0);
        chk("full1_clear", 32'(acc_clear), 32'd0);
`ifdef RESULT_PARITY_EN
        chk("par300", 32'(out_parity), 32'd0);
`endif
        tick();
        chk_word("full2", 0, 2, 0);
`ifdef RESULT_PARITY_EN
        chk("par0", 32'(out_parity), 32'd0);
`endif
        tick();
        chk_word("full3", 1023, 3, 1);
        chk("full3_done", 32'(done), 32'd0);
`ifdef RESULT_PARITY_EN
        chk("par1023", 32'(out_parity), 32'd0);
`endif
        tick();
        chk("full_done", 32'(done), 32'd1);
        chk_quiet("full_end");
        tick();
        chk("full_done_pulse", 32'(done), 32'd0);

        // Backpressure on index 1
        hs_cnt = 0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk_word("bp0", 5, 0, 0);
        tick();
        chk_word("bp1", 300, 1, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_word("bp_hold", 300, 1, 0);
        end
        out_ready = 1'b1;
        tick();
        chk_word("bp2", 0, 2, 0);
        tick();
        chk_word("bp3", 1023, 3, 1);
        tick();
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_hs", 32'(hs_cnt), 32'd4);

        // start during stream and acc_flat change after snapshot
        tick();
        clr_cnt = 0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk_word("ign0", 5, 0, 0);
        tick();
        chk_word("ign1", 300, 1, 0);
        tick();
        chk_word("ign2", 0, 2, 0);
        start    = 1'b1;
        acc_flat = {4{10'd7}};
        tick();
        start = 1'b0;
        chk_word("ign3", 1023, 3, 1);
        chk("ign3_clear", 32'(acc_clear), 32'd0);
        tick();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_clears", 32'(clr_cnt), 32'd1);

        // start in the done cycle is accepted
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_word("dstart0", 7, 0, 0);
        chk("dstart0_clear", 32'(acc_clear), 32'd1);
`ifdef RESULT_PARITY_EN
        chk("par7", 32'(out_parity), 32'd1);
`endif
        repeat (4) tick();
        chk("dstart_done", 32'(done), 32'd1);
        tick();

        // Reset mid-stream
        acc_flat = {10'd1023, 10'd0, 10'd300, 10'd5};
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_word("mid1", 300, 1, 0);
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_rst");
        chk("mid_rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst_n    = 1'b1;
        acc_flat = {10'd4, 10'd3, 10'd2, 10'd1};
        tick();
        chk_quiet("post_rst");
        chk("post_rst_done", 32'(done), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_word("re0", 1, 0, 0);
        chk("re0_clear", 32'(acc_clear), 32'd1);
        tick();
        chk_word("re1", 2, 1, 0);
        tick();
        chk_word("re2", 3, 2, 0);
        tick();
        chk_word("re3", 4, 3, 1);
        tick();
        chk("re_done", 32'(done), 32'd1);
        chk("re_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
